// File: rtl/csel_adder_pipe_pkg.sv
// Shared arithmetic helpers for the pipelined carry-select adder.
package arith_pkg;

   // Number of carry-select chunks (and therefore pipeline stages)
   function automatic int unsigned csel_nb(input int unsigned width, input int unsigned block);
      return (block == 0) ? 1 : width / block;
   endfunction

   // Legal geometry: chunk size within the operand, operand an exact multiple of it
   function automatic bit csel_cfg_ok(input int unsigned width, input int unsigned block);
      return (block >= 1) && (block <= width) && ((width % block) == 0);
   endfunction

endpackage

// File: rtl/csel_adder_pipe_chunk.sv
// One carry-select chunk: two speculative ripple sums, selected by the real carry-in.
module csel_chunk #(
   parameter int unsigned BLOCK = 8
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             cin,
   output logic [BLOCK-1:0] sum,
   output logic             cout,
   output logic             c_msb_in
);

   logic [BLOCK:0]   w_c0;
   logic [BLOCK:0]   w_c1;
   logic [BLOCK-1:0] w_s0;
   logic [BLOCK-1:0] w_s1;

   // Speculative ripple chains for carry-in 0 and carry-in 1
   always_comb begin
      w_c0    = '0;
      w_c1    = '0;
      w_s0    = '0;
      w_s1    = '0;
      w_c1[0] = 1'b1;
      for (int unsigned i = 0; i < BLOCK; i++) begin
         w_s0[i]   = a[i] ^ b[i] ^ w_c0[i];
         w_c0[i+1] = (a[i] & b[i]) | (w_c0[i] & (a[i] ^ b[i]));
         w_s1[i]   = a[i] ^ b[i] ^ w_c1[i];
         w_c1[i+1] = (a[i] & b[i]) | (w_c1[i] & (a[i] ^ b[i]));
      end
   end

   // Late select once the incoming carry is known
   always_comb begin
      sum      = cin ? w_s1 : w_s0;
      cout     = cin ? w_c1[BLOCK] : w_c0[BLOCK];
      c_msb_in = cin ? w_c1[BLOCK-1] : w_c0[BLOCK-1];
   end

endmodule

// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor: one BLOCK-bit chunk resolved per stage,
// valid/ready streaming with a single global advance enable.
module csel_adder_pipe
   import arith_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned BLOCK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int unsigned NB = csel_nb(WIDTH, BLOCK);

   if (!csel_cfg_ok(WIDTH, BLOCK)) begin : g_cfg_err
      $error("csel_adder_pipe: WIDTH (%0d) must be a multiple of BLOCK (%0d), 1 <= BLOCK <= WIDTH",
             WIDTH, BLOCK);
   end

   logic             w_en;
   logic [WIDTH-1:0] w_b_eff;
   logic             w_c0;

   // Global advance enable and subtract conditioning (A - B - cin = A + ~B + ~cin)
   always_comb begin
      w_en    = ~out_valid | out_ready;
      w_b_eff = in_sub ? ~in_b : in_b;
      w_c0    = in_sub ^ in_cin;
   end

   assign in_ready = w_en;

   for (genvar k = 0; k < NB; k++) begin : g_stage
      localparam int unsigned LO = k * BLOCK;

      // Operand chunks k..NB-1 still unresolved on entry to this stage
      logic [WIDTH-LO-1:0]   w_a_in;
      logic [WIDTH-LO-1:0]   w_b_in;
      logic                  w_c_in;
      logic                  w_v_in;
      logic [BLOCK-1:0]      w_sum;
      logic                  w_cout;
      logic                  w_cmsb;
      logic [LO+BLOCK-1:0]   w_sum_nxt;
      logic [LO+BLOCK-1:0]   r_sum;
      logic                  r_c;
      logic                  r_v;

      if (k == 0) begin : g_src
         assign w_a_in    = in_a;
         assign w_b_in    = w_b_eff;
         assign w_c_in    = w_c0;
         assign w_v_in    = in_valid;
         assign w_sum_nxt = w_sum;
      end else begin : g_src
         assign w_a_in    = g_stage[k-1].g_ops.r_a;
         assign w_b_in    = g_stage[k-1].g_ops.r_b;
         assign w_c_in    = g_stage[k-1].r_c;
         assign w_v_in    = g_stage[k-1].r_v;
         assign w_sum_nxt = {w_sum, g_stage[k-1].r_sum};
      end

      csel_chunk #(.BLOCK(BLOCK)) u_chunk (
         .a        (w_a_in[BLOCK-1:0]),
         .b        (w_b_in[BLOCK-1:0]),
         .cin      (w_c_in),
         .sum      (w_sum),
         .cout     (w_cout),
         .c_msb_in (w_cmsb)
      );

      // Advance this stage; data loads only behind a valid beat so bubbles leave it untouched
      always_ff @(posedge clk) begin
         if (rst) begin
            r_v   <= 1'b0;
            r_c   <= 1'b0;
            r_sum <= '0;
         end else if (w_en) begin
            r_v <= w_v_in;
            if (w_v_in) begin
               r_c   <= w_cout;
               r_sum <= w_sum_nxt;
            end
         end
      end

      if (k < NB - 1) begin : g_ops
         logic [WIDTH-LO-BLOCK-1:0] r_a;
         logic [WIDTH-LO-BLOCK-1:0] r_b;
         logic                      w_unused_cmsb;

         assign w_unused_cmsb = w_cmsb;

         // Skew buffer: carry the still-unresolved upper operand chunks forward
         always_ff @(posedge clk) begin
            if (rst) begin
               r_a <= '0;
               r_b <= '0;
            end else if (w_en && w_v_in) begin
               r_a <= w_a_in[WIDTH-LO-1:BLOCK];
               r_b <= w_b_in[WIDTH-LO-1:BLOCK];
            end
         end
      end else begin : g_last
         logic r_cmsb;

         // Carry into the MSB is kept alongside carry-out for the overflow flag
         always_ff @(posedge clk) begin
            if (rst) begin
               r_cmsb <= 1'b0;
            end else if (w_en && w_v_in) begin
               r_cmsb <= w_cmsb;
            end
         end

         assign out_valid = r_v;
         assign out_sum   = r_sum;
         assign out_cout  = r_c;
         assign out_ovf   = r_cmsb ^ r_c;
      end
   end

endmodule
